// File: rtl/fifo_pkt_reader.sv
// Receive-side packet reader: hunts for SYNC, reassembles length-prefixed frames,
// verifies the additive checksum and streams only verified payloads downstream.
module fifo_pkt_reader #(
    parameter logic [7:0] SYNC    = 8'h7E,
    parameter int         MAX_LEN = 64,
    parameter int         LEN_W   = 7,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        srst_n,
    output logic        fifo_rd_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        pkt_ok,
    output logic        err_len,
    output logic        err_csum,
    output logic        err_timeout,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       acc_q, acc_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             skid_full_q, skid_full_d;
    logic [7:0]       skid_data_q, skid_data_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             pkt_ok_q, pkt_ok_d;
    logic             err_len_q, err_len_d;
    logic             err_csum_q, err_csum_d;
    logic             err_timeout_q, err_timeout_d;
    logic [15:0]      good_cnt_q, good_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic [7:0]       pkt_mem_q [MAX_LEN];

    logic             in_frame;
    logic             byte_vld;
    logic [7:0]       byte_in;
    logic             mem_we;
    logic [LEN_W-1:0] rd_nxt;

    assign in_frame   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    assign fifo_rd_en = (in_frame || (state_q == ST_HUNT)) && !skid_full_q && !fifo_empty;

    // The skid byte always has priority so bytes are consumed in arrival order.
    assign byte_vld = (state_q != ST_DRAIN) && (skid_full_q || fifo_valid);
    assign byte_in  = skid_full_q ? skid_data_q : fifo_dout;
    assign mem_we   = (state_q == ST_PAYLOAD) && byte_vld;
    assign rd_nxt   = rd_idx_q + LEN_W'(1);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        rd_idx_d      = rd_idx_q;
        acc_d         = acc_q;
        timer_d       = timer_q;
        skid_full_d   = skid_full_q;
        skid_data_d   = skid_data_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        pkt_ok_d      = 1'b0;
        err_len_d     = 1'b0;
        err_csum_d    = 1'b0;
        err_timeout_d = 1'b0;
        good_cnt_d    = good_cnt_q;
        err_cnt_d     = err_cnt_q;

        // A byte still in flight when reads stop must land somewhere: park it in the skid.
        if (state_q == ST_DRAIN) begin
            if (fifo_valid) begin
                skid_full_d = 1'b1;
                skid_data_d = fifo_dout;
            end
        end else if (skid_full_q) begin
            skid_full_d = fifo_valid;
            if (fifo_valid) begin
                skid_data_d = fifo_dout;
            end
        end

        if (in_frame) begin
            if (byte_vld) begin
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                timer_d       = '0;
                err_timeout_d = 1'b1;
                state_d       = ST_HUNT;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        case (state_q)
            ST_HUNT: begin
                if (byte_vld && (byte_in == SYNC)) begin
                    state_d = ST_LEN;
                    timer_d = '0;
                end
            end
            ST_LEN: begin
                if (byte_vld) begin
                    if ((byte_in == 8'd0) || (byte_in > MAX_LEN_B)) begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        len_d   = byte_in[LEN_W-1:0];
                        idx_d   = '0;
                        acc_d   = 8'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_vld) begin
                    acc_d = acc_q + byte_in;
                    idx_d = idx_q + LEN_W'(1);
                    if ((idx_q + LEN_W'(1)) == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (byte_vld) begin
                    if (byte_in == acc_q) begin
                        pkt_ok_d    = 1'b1;
                        good_cnt_d  = good_cnt_q + 16'd1;
                        state_d     = ST_DRAIN;
                        rd_idx_d    = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = pkt_mem_q[0];
                        out_last_d  = (len_q == LEN_W'(1));
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = 8'd0;
                        state_d     = ST_HUNT;
                    end else begin
                        rd_idx_d   = rd_nxt;
                        out_data_d = pkt_mem_q[rd_nxt[AW-1:0]];
                        out_last_d = (rd_nxt == (len_q - LEN_W'(1)));
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (err_len_d || err_csum_d || err_timeout_d) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q       <= ST_HUNT;
            len_q         <= '0;
            idx_q         <= '0;
            rd_idx_q      <= '0;
            acc_q         <= 8'd0;
            timer_q       <= '0;
            skid_full_q   <= 1'b0;
            skid_data_q   <= 8'd0;
            out_data_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            pkt_ok_q      <= 1'b0;
            err_len_q     <= 1'b0;
            err_csum_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            good_cnt_q    <= 16'd0;
            err_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            rd_idx_q      <= rd_idx_d;
            acc_q         <= acc_d;
            timer_q       <= timer_d;
            skid_full_q   <= skid_full_d;
            skid_data_q   <= skid_data_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            pkt_ok_q      <= pkt_ok_d;
            err_len_q     <= err_len_d;
            err_csum_q    <= err_csum_d;
            err_timeout_q <= err_timeout_d;
            good_cnt_q    <= good_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // Packet storage carries no reset; stale contents are never presented unverified.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            pkt_mem_q[idx_q[AW-1:0]] <= byte_in;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign pkt_ok      = pkt_ok_q;
    assign err_len     = err_len_q;
    assign err_csum    = err_csum_q;
    assign err_timeout = err_timeout_q;
    assign good_cnt    = good_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Receive-side consumer for the byte FIFO. It drains bytes through the FIFO read port and hunts for a sync byte.
- It reassembles length-prefixed, checksummed packets into an internal buffer and hands only verified packets downstream on a valid/ready stream.
- It tolerates read-side jitter: the FIFO may return a byte any number of cycles after the request while fifo_rd_en is held.

Parameters:
- SYNC, 8'h7E, frame start byte.
- MAX_LEN, 64, maximum payload bytes; buffer depth.
- LEN_W, 7, width of length/index counters; must satisfy 2^LEN_W > MAX_LEN.
- TIMEOUT, 1024, idle cycles allowed between bytes inside a frame.

Ports:
- clk, in, 1, system clock.
- srst_n, in, 1, asynchronous active-low reset.
- fifo_rd_en, out, 1, level read request to the FIFO.
- fifo_empty, in, 1, FIFO empty flag.
- fifo_dout, in, 8, FIFO read data.
- fifo_valid, in, 1, fifo_dout carries one popped byte this cycle.
- out_data, out, 8, payload byte.
- out_valid, out, 1, out_data valid.
- out_last, out, 1, final payload byte of the packet.
- out_ready, in, 1, downstream accepts the byte.
- pkt_ok, out, 1, one-cycle pulse when a packet passes its checksum.
- err_len, out, 1, one-cycle pulse on illegal length.
- err_csum, out, 1, one-cycle pulse on checksum mismatch.
- err_timeout, out, 1, one-cycle pulse on mid-frame timeout.
- good_cnt, out, 16, count of verified packets; wraps.
- err_cnt, out, 16, count of all error pulses; wraps.

Behaviour:
- Frame format: SYNC, L, payload[0..L-1], C, where C = sum(payload) mod 256. L is legal when 1 <= L <= MAX_LEN.
- Reset (srst_n low, any time including mid-frame):
  - state=HUNT; skid buffer empty; timer=0; all outputs 0.
  - Buffer contents are don't-care.
  - After release, the first action is HUNT with fifo_rd_en = !fifo_empty.
- fifo_rd_en = !fifo_empty while in HUNT, LEN, PAYLOAD or CSUM and the skid buffer is empty; otherwise 0. Purely a function of registered state plus fifo_empty.
- Byte source: each cycle the byte to process is the skid byte if the skid is full, else fifo_dout when fifo_valid=1. Exactly one byte is processed per cycle.
- A fifo_valid arriving while in DRAIN, or while the skid is being consumed, is captured into the 1-entry skid. A byte is never dropped.
- A fifo_valid with a full skid is a protocol violation; behaviour is undefined and flagged by a bench assertion.
- HUNT: a byte equal to SYNC goes to LEN; any other byte is discarded.
- LEN:
  - Illegal L (0 or > MAX_LEN): pulse err_len, go to HUNT.
  - Legal L: latch L, clear index and checksum accumulator, go to PAYLOAD.
- PAYLOAD: write buf[index]=byte, add byte to the 8-bit accumulator (mod 256), increment index. When index reaches L, go to CSUM.
- CSUM:
  - Byte == accumulator: pulse pkt_ok, increment good_cnt, go to DRAIN with read index=0.
  - Otherwise: pulse err_csum, go to HUNT.
  - A SYNC-valued byte is treated as data inside LEN, PAYLOAD and CSUM. There is no resync mid-frame.
- DRAIN:
  - out_valid=1, out_data=buf[rd_index], out_last=(rd_index==L-1).
  - On out_valid && out_ready: advance rd_index. On the last byte, go to HUNT with out_valid low the next cycle.
  - With out_ready low: out_data, out_last and out_valid hold stable.
  - Each output byte registered; one byte per cycle at full throughput.
- Timeout:
  - In LEN, PAYLOAD or CSUM, the timer counts cycles with no byte processed and clears on each byte.
  - When the timer reaches TIMEOUT: pulse err_timeout, go to HUNT.
  - Not active in HUNT or DRAIN.
- err_cnt increments once per err_len, err_csum or err_timeout pulse. Only one can fire per cycle.
- Latency: pkt_ok fires the cycle after the checksum byte is processed; the first out_valid fires in the same cycle as pkt_ok.
- No packet data reaches the output before its checksum passes. Failed packets produce no out_valid.

Test Plan:
- Good packet: FIFO holds 7E 03 10 20 30 60 → pkt_ok once, then out_data 10,20,30 with out_last on 30; good_cnt=1.
- Bad checksum: 7E 02 01 02 04 → err_csum, no out_valid, err_cnt=1. Then 7E 01 AA AA → one good packet AA.
- Garbage and illegal length:
  - 55 7E 7E 41 7E 00 → first 7E enters LEN; second 7E (126 > 64) gives err_len; 41 is skipped in HUNT; 7E 00 gives err_len.
  - Expect err_cnt=2.
- Backpressure plus skid: 7E 02 05 06 0B then 7E 01 09 09 streamed back-to-back, out_ready toggled 1,0,0,1.
  - Bytes held stable while out_ready is low.
  - Second packet is received intact, including the byte that lands during DRAIN.
- Jittered reads and timeout:
  - fifo_valid gaps of 0–7 cycles inside 7E 04 01 01 01 01 04 → good packet.
  - Stall 1024 cycles after 7E 02 01 → err_timeout, state HUNT.
- Reset mid-PAYLOAD: srst_n low for 1 cycle after 7E 05 AA → all outputs 0; the next good frame 7E 01 33 33 is delivered correctly.
